// File: rtl/my_axi4_lite_mst_pkg.sv
// Shared types and constants for the command-driven AXI4-Lite master.
package my_axi4_lite_mst_pkg;

    // Storage widths for the latched command; the master slices them to its parameters.
    localparam int unsigned MAX_ADDR_W = 64;
    localparam int unsigned MAX_DATA_W = 64;
    localparam int unsigned MAX_STRB_W = MAX_DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_RSP
    } state_e;

    typedef struct packed {
        logic                  wr;
        logic [MAX_ADDR_W-1:0] addr;
        logic [MAX_DATA_W-1:0] wdata;
        logic [MAX_STRB_W-1:0] wstrb;
    } cmd_t;

endpackage

// File: rtl/aix4_lite_if.sv
// AXI4-Lite bundle with master and slave views.
interface aix4_lite_if #(
    parameter int unsigned ADDR_BIT_WIDTH = 4,
    parameter int unsigned DATA_BIT_WIDTH = 32
);
    logic                          awvalid;
    logic                          awready;
    logic [ADDR_BIT_WIDTH-1:0]     awaddr;
    logic                          wvalid;
    logic                          wready;
    logic [DATA_BIT_WIDTH-1:0]     wdata;
    logic [DATA_BIT_WIDTH/8-1:0]   wstrb;
    logic                          bvalid;
    logic                          bready;
    logic [1:0]                    bresp;
    logic                          arvalid;
    logic                          arready;
    logic [ADDR_BIT_WIDTH-1:0]     araddr;
    logic                          rvalid;
    logic                          rready;
    logic [DATA_BIT_WIDTH-1:0]     rdata;
    logic [1:0]                    rresp;

    modport mst_port (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slv_port (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/my_axi4_lite_cmd_mst.sv
// Command-driven AXI4-Lite master: one register access per command, one
// transaction outstanding, response returned with a saturating latency count.
module my_axi4_lite_cmd_mst
    import my_axi4_lite_mst_pkg::*;
#(
    parameter int unsigned ADDR_BIT_WIDTH = 4,
    parameter int unsigned DATA_BIT_WIDTH = 32,
    parameter int unsigned LAT_BIT_WIDTH  = 8
) (
    input  logic                        i_clk,
    input  logic                        i_async_rst_n,
    input  logic                        i_cmd_valid,
    output logic                        o_cmd_ready,
    input  logic                        i_cmd_wr,
    input  logic [ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
    input  logic [DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,
    output logic                        o_rsp_valid,
    input  logic                        i_rsp_ready,
    output logic                        o_rsp_wr,
    output logic [DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
    output logic [1:0]                  o_rsp_resp,
    output logic [LAT_BIT_WIDTH-1:0]    o_rsp_lat,
    aix4_lite_if.mst_port               if_m_axi4_lite
);

    localparam int unsigned STRB_W = DATA_BIT_WIDTH / 8;
    localparam logic [LAT_BIT_WIDTH-1:0] LAT_MAX = '1;

    if (DATA_BIT_WIDTH != 32 && DATA_BIT_WIDTH != 64) begin : g_bad_data_w
        $error("my_axi4_lite_cmd_mst: DATA_BIT_WIDTH must be 32 or 64");
    end
    if (ADDR_BIT_WIDTH > MAX_ADDR_W) begin : g_bad_addr_max
        $error("my_axi4_lite_cmd_mst: ADDR_BIT_WIDTH exceeds command storage");
    end
    if (int'(if_m_axi4_lite.ADDR_BIT_WIDTH) != int'(ADDR_BIT_WIDTH)) begin : g_bad_if_addr
        $error("my_axi4_lite_cmd_mst: ADDR_BIT_WIDTH differs from interface");
    end
    if (int'(if_m_axi4_lite.DATA_BIT_WIDTH) != int'(DATA_BIT_WIDTH)) begin : g_bad_if_data
        $error("my_axi4_lite_cmd_mst: DATA_BIT_WIDTH differs from interface");
    end

    state_e                     r_state;
    state_e                     w_state_nxt;
    cmd_t                       r_cmd;
    logic                       r_awvalid;
    logic                       r_wvalid;
    logic                       r_bready;
    logic                       r_arvalid;
    logic                       r_rready;
    logic                       r_aw_done;
    logic                       r_w_done;
    logic                       r_rsp_valid;
    logic                       r_rsp_wr;
    logic [DATA_BIT_WIDTH-1:0]  r_rsp_rdata;
    logic [1:0]                 r_rsp_resp;
    logic [LAT_BIT_WIDTH-1:0]   r_lat;

    logic w_cmd_hs, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_rsp_hs;
    logic w_aw_done, w_w_done, w_active, w_unused_cmd;

    assign w_cmd_hs  = i_cmd_valid && o_cmd_ready;
    assign w_aw_hs   = r_awvalid && if_m_axi4_lite.awready;
    assign w_w_hs    = r_wvalid && if_m_axi4_lite.wready;
    assign w_b_hs    = r_bready && if_m_axi4_lite.bvalid;
    assign w_ar_hs   = r_arvalid && if_m_axi4_lite.arready;
    assign w_r_hs    = r_rready && if_m_axi4_lite.rvalid;
    assign w_rsp_hs  = r_rsp_valid && i_rsp_ready;
    assign w_aw_done = r_aw_done || w_aw_hs;
    assign w_w_done  = r_w_done || w_w_hs;
    assign w_active  = (r_state == ST_WR) || (r_state == ST_WR_RESP) ||
                       (r_state == ST_RD_ADDR) || (r_state == ST_RD_DATA);

    // Command storage is sized for the widest build; the upper bits stay zero.
    assign w_unused_cmd = ^r_cmd;

    assign o_cmd_ready = (r_state == ST_IDLE);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_wr    = r_rsp_wr;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_resp  = r_rsp_resp;
    assign o_rsp_lat   = r_lat;

    assign if_m_axi4_lite.awvalid = r_awvalid;
    assign if_m_axi4_lite.awaddr  = ADDR_BIT_WIDTH'(r_cmd.addr);
    assign if_m_axi4_lite.wvalid  = r_wvalid;
    assign if_m_axi4_lite.wdata   = DATA_BIT_WIDTH'(r_cmd.wdata);
    assign if_m_axi4_lite.wstrb   = STRB_W'(r_cmd.wstrb);
    assign if_m_axi4_lite.bready  = r_bready;
    assign if_m_axi4_lite.arvalid = r_arvalid;
    assign if_m_axi4_lite.araddr  = ADDR_BIT_WIDTH'(r_cmd.addr);
    assign if_m_axi4_lite.rready  = r_rready;

    // State register.
    always_ff @(posedge i_clk or negedge i_async_rst_n) begin
        if (!i_async_rst_n) r_state <= ST_IDLE;
        else                r_state <= w_state_nxt;
    end

    // Next-state decode from the channel handshakes.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:    if (w_cmd_hs) w_state_nxt = i_cmd_wr ? ST_WR : ST_RD_ADDR;
            ST_WR:      if (w_aw_done && w_w_done) w_state_nxt = ST_WR_RESP;
            ST_WR_RESP: if (w_b_hs) w_state_nxt = ST_RSP;
            ST_RD_ADDR: if (w_ar_hs) w_state_nxt = ST_RD_DATA;
            ST_RD_DATA: if (w_r_hs) w_state_nxt = ST_RSP;
            ST_RSP:     if (w_rsp_hs) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered AXI channel controls, command latch, response capture and latency count.
    always_ff @(posedge i_clk or negedge i_async_rst_n) begin
        if (!i_async_rst_n) begin
            r_cmd       <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_wr    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= RESP_OKAY;
            r_lat       <= '0;
        end else begin
            if (w_active && r_lat != LAT_MAX) r_lat <= r_lat + 1'b1;
            unique case (r_state)
                ST_IDLE: if (w_cmd_hs) begin
                    r_cmd.wr    <= i_cmd_wr;
                    r_cmd.addr  <= MAX_ADDR_W'(i_cmd_addr);
                    r_cmd.wdata <= MAX_DATA_W'(i_cmd_wdata);
                    r_cmd.wstrb <= MAX_STRB_W'(i_cmd_wstrb);
                    r_lat       <= '0;
                    r_aw_done   <= 1'b0;
                    r_w_done    <= 1'b0;
                    r_awvalid   <= i_cmd_wr;
                    r_wvalid    <= i_cmd_wr;
                    r_arvalid   <= !i_cmd_wr;
                end
                ST_WR: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_done && w_w_done) r_bready <= 1'b1;
                end
                ST_WR_RESP: if (w_b_hs) begin
                    r_bready    <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_wr    <= 1'b1;
                    r_rsp_rdata <= '0;
                    r_rsp_resp  <= if_m_axi4_lite.bresp;
                end
                ST_RD_ADDR: if (w_ar_hs) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                end
                ST_RD_DATA: if (w_r_hs) begin
                    r_rready    <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_wr    <= 1'b0;
                    r_rsp_rdata <= if_m_axi4_lite.rdata;
                    r_rsp_resp  <= if_m_axi4_lite.rresp;
                end
                ST_RSP: if (w_rsp_hs) r_rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_my_axi4_lite_cmd_mst.sv
// Directed bench: a behavioural 4-register AXI4-Lite slave with programmable
// ready delays and write response code sits behind the master.
module tb_my_axi4_lite_cmd_mst;
    import my_axi4_lite_mst_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_cmd_valid, i_cmd_wr, i_rsp_ready;
    logic [3:0]  i_cmd_addr, i_cmd_wstrb;
    logic [31:0] i_cmd_wdata;
    logic        o_cmd_ready, o_rsp_valid, o_rsp_wr;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_resp;
    logic [7:0]  o_rsp_lat;

    int n_checks = 0;
    int n_errors = 0;

    aix4_lite_if #(.ADDR_BIT_WIDTH(4), .DATA_BIT_WIDTH(32)) axi ();

    my_axi4_lite_cmd_mst #(.ADDR_BIT_WIDTH(4), .DATA_BIT_WIDTH(32), .LAT_BIT_WIDTH(8)) dut (
        .i_clk(clk), .i_async_rst_n(rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_wr(i_cmd_wr),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_wr(o_rsp_wr),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp), .o_rsp_lat(o_rsp_lat),
        .if_m_axi4_lite(axi)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural slave ----------------
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]  bresp_cfg = RESP_OKAY;
    int          aw_cnt, w_cnt, ar_cnt;
    logic        aw_got, w_got;
    logic [3:0]  s_awaddr, s_wstrb;
    logic [31:0] s_wdata;
    logic [31:0] mem [4];
    logic        s_aw_hs, s_w_hs, s_ar_hs;
    logic [3:0]  s_addr_eff, s_strb_eff;
    logic [31:0] s_data_eff;

    initial for (int i = 0; i < 4; i++) mem[i] = '0;

    assign axi.awready = axi.awvalid && !aw_got && (aw_cnt >= aw_delay);
    assign axi.wready  = axi.wvalid && !w_got && (w_cnt >= w_delay);
    assign axi.arready = axi.arvalid && !axi.rvalid && (ar_cnt >= ar_delay);
    assign s_aw_hs     = axi.awvalid && axi.awready;
    assign s_w_hs      = axi.wvalid && axi.wready;
    assign s_ar_hs     = axi.arvalid && axi.arready;
    assign s_addr_eff  = s_aw_hs ? axi.awaddr : s_awaddr;
    assign s_data_eff  = s_w_hs ? axi.wdata : s_wdata;
    assign s_strb_eff  = s_w_hs ? axi.wstrb : s_wstrb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0;
            axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
            axi.rvalid <= 1'b0; axi.rdata <= '0; axi.rresp <= 2'b00;
        end else begin
            if (axi.awvalid && !axi.awready) aw_cnt <= aw_cnt + 1;
            if (axi.wvalid && !axi.wready)   w_cnt  <= w_cnt + 1;
            if (axi.arvalid && !axi.arready) ar_cnt <= ar_cnt + 1;
            if (s_aw_hs) begin aw_got <= 1'b1; aw_cnt <= 0; s_awaddr <= axi.awaddr; end
            if (s_w_hs)  begin w_got <= 1'b1; w_cnt <= 0; s_wdata <= axi.wdata; s_wstrb <= axi.wstrb; end
            if ((aw_got || s_aw_hs) && (w_got || s_w_hs) && !axi.bvalid) begin
                for (int b = 0; b < 4; b++)
                    if (s_strb_eff[b]) mem[s_addr_eff[3:2]][8*b +: 8] <= s_data_eff[8*b +: 8];
                axi.bvalid <= 1'b1;
                axi.bresp  <= bresp_cfg;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
            if (s_ar_hs) begin
                ar_cnt     <= 0;
                axi.rvalid <= 1'b1;
                axi.rdata  <= mem[axi.araddr[3:2]];
                axi.rresp  <= RESP_OKAY;
            end
            if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at posedge+1 after the command handshake.
    task automatic do_cmd(input logic wr, input logic [3:0] addr, input logic [31:0] wd, input logic [3:0] ws);
        int k = 0;
        while (!o_cmd_ready && k < 100) begin @(negedge clk); k++; end
        check("cmd_ready_before_cmd", o_cmd_ready, 1);
        i_cmd_valid = 1'b1; i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_wdata = wd; i_cmd_wstrb = ws;
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        int k = 0;
        @(negedge clk);
        while (!o_rsp_valid && k < budget) begin @(negedge clk); k++; end
        check(tag, o_rsp_valid, 1);
    endtask

    task automatic finish_rsp();
        i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        i_rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_rsp(input string tag, input logic wr, input logic [31:0] rd,
                             input logic [1:0] resp, input logic [7:0] lat, input logic chk_lat);
        check({tag, "_wr"}, o_rsp_wr, wr);
        check({tag, "_rdata"}, o_rsp_rdata, rd);
        check({tag, "_resp"}, o_rsp_resp, resp);
        if (chk_lat) check({tag, "_lat"}, o_rsp_lat, lat);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_wr = 1'b0; i_cmd_addr = '0;
        i_cmd_wdata = '0; i_cmd_wstrb = '0; i_rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_awvalid", axi.awvalid, 0);
        check("rst_wvalid", axi.wvalid, 0);
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_bready", axi.bready, 0);
        check("rst_rready", axi.rready, 0);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_rsp_rdata", o_rsp_rdata, 0);
        check("rst_rsp_lat", o_rsp_lat, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", o_cmd_ready, 1);

        // Full-word write then read back, ideal slave.
        do_cmd(1'b1, 4'h4, 32'hDEADBEEF, 4'hF);
        wait_rsp("t1w_valid", 50);
        check_rsp("t1w", 1'b1, 32'h0, RESP_OKAY, 8'd2, 1'b1);
        finish_rsp();
        do_cmd(1'b0, 4'h4, 32'h0, 4'h0);
        wait_rsp("t1r_valid", 50);
        check_rsp("t1r", 1'b0, 32'hDEADBEEF, RESP_OKAY, 8'd2, 1'b1);
        finish_rsp();

        // Partial-strobe write merges the low two bytes only.
        do_cmd(1'b1, 4'h4, 32'h11223344, 4'h3);
        wait_rsp("t2w_valid", 50);
        check_rsp("t2w", 1'b1, 32'h0, RESP_OKAY, 8'd2, 1'b0);
        finish_rsp();
        do_cmd(1'b0, 4'h4, 32'h0, 4'h0);
        wait_rsp("t2r_valid", 50);
        check_rsp("t2r", 1'b0, 32'hDEAD3344, RESP_OKAY, 8'd2, 1'b0);
        finish_rsp();

        // Response back-pressure for five cycles.
        do_cmd(1'b0, 4'h4, 32'h0, 4'h0);
        wait_rsp("t3_valid", 50);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", o_rsp_valid, 1);
            check("t3_hold_cmd_ready", o_cmd_ready, 0);
            check("t3_hold_rdata", o_rsp_rdata, 32'hDEAD3344);
            check("t3_hold_lat", o_rsp_lat, 8'd2);
            @(negedge clk);
        end
        finish_rsp();
        check("t3_cmd_ready_after", o_cmd_ready, 1);
        check("t3_valid_after", o_rsp_valid, 0);

        // W accepted three cycles before AW, slave returns SLVERR.
        aw_delay = 3; bresp_cfg = RESP_SLVERR;
        do_cmd(1'b1, 4'h8, 32'hA5A5A5A5, 4'hF);
        @(negedge clk);
        check("t4_aw_initial", axi.awvalid, 1);
        check("t4_w_initial", axi.wvalid, 1);
        @(negedge clk);
        check("t4_w_dropped", axi.wvalid, 0);
        check("t4_aw_held", axi.awvalid, 1);
        repeat (2) @(negedge clk);
        check("t4_aw_still_held", axi.awvalid, 1);
        check("t4_bready_not_yet", axi.bready, 0);
        @(negedge clk);
        check("t4_aw_dropped", axi.awvalid, 0);
        check("t4_bready", axi.bready, 1);
        wait_rsp("t4_valid", 50);
        check_rsp("t4", 1'b1, 32'h0, RESP_SLVERR, 8'd5, 1'b1);
        finish_rsp();
        aw_delay = 0; bresp_cfg = RESP_OKAY;

        // Latency saturates when arready is held off for 300 cycles.
        ar_delay = 300;
        do_cmd(1'b0, 4'hC, 32'h0, 4'h0);
        wait_rsp("t5_valid", 1000);
        check_rsp("t5", 1'b0, 32'h0, RESP_OKAY, 8'd255, 1'b1);
        finish_rsp();
        ar_delay = 0;

        // Asynchronous reset in the middle of a stalled write.
        aw_delay = 50; w_delay = 50;
        do_cmd(1'b1, 4'h0, 32'hCAFEF00D, 4'hF);
        @(posedge clk); #2;
        check("t6_aw_before_rst", axi.awvalid, 1);
        rst_n = 1'b0;
        #1;
        check("t6_aw_rst", axi.awvalid, 0);
        check("t6_w_rst", axi.wvalid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        aw_delay = 0; w_delay = 0;
        @(negedge clk);
        check("t6_cmd_ready", o_cmd_ready, 1);
        check("t6_rsp_valid", o_rsp_valid, 0);

        // Master is usable again and the aborted write never landed.
        do_cmd(1'b0, 4'h4, 32'h0, 4'h0);
        wait_rsp("t7a_valid", 50);
        check_rsp("t7a", 1'b0, 32'hDEAD3344, RESP_OKAY, 8'd2, 1'b1);
        finish_rsp();
        do_cmd(1'b0, 4'h0, 32'h0, 4'h0);
        wait_rsp("t7b_valid", 50);
        check_rsp("t7b", 1'b0, 32'h0, RESP_OKAY, 8'd2, 1'b0);
        finish_rsp();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
